alu_exec_unit: RTL and testbench

- Execute-stage ALU directly downstream of the secondary instruction decoder.
- Consumes the decoder's 4-bit alu_op ({funct7[5], funct3} encoding) plus two XLEN operands.
- Produces a registered result, a zero flag and an illegal-op flag over a valid/ready handshake.
- Logical/arithmetic ops take a fixed 1 cycle. Shifts are iterative at 1 bit per cycle, so the unit back-pressures the decode stage.

---
 rtl/alu_exec_unit.sv | 137 +++++++++++++
 tb/tb_alu_exec_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logical/arithmetic ops, iterative 1-bit-per-cycle shifts,
// registered result/zero/illegal flags delivered over a valid/ready handshake.
module alu_exec_unit #(
    parameter int XLEN = 32,
    parameter int SHW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal_op,
    output logic            busy
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_AND  = 4'b0111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state_q;
    logic [3:0]        op_q;
    logic [XLEN-1:0]   wrk_q;
    logic [SHW-1:0]    cnt_q;
    logic [XLEN-1:0]   result_q;
    logic              zero_q;
    logic              illegal_q;

    logic [SHW-1:0]    shamt;
    logic              is_shift;
    logic              legal;
    logic [XLEN-1:0]   alu_res_d;
    logic [XLEN-1:0]   shifted_d;

    function automatic logic [XLEN-1:0] shift_one(input logic [3:0] op, input logic [XLEN-1:0] v);
        case (op)
            OP_SLL:  return {v[XLEN-2:0], 1'b0};
            OP_SRA:  return {v[XLEN-1], v[XLEN-1:1]};
            default: return {1'b0, v[XLEN-1:1]};
        endcase
    endfunction

    assign shamt     = op_b[SHW-1:0];
    assign is_shift  = (alu_op == OP_SLL) || (alu_op == OP_SRL) || (alu_op == OP_SRA);
    assign shifted_d = shift_one(op_q, wrk_q);

    // Single-cycle result; a shift reaching here has shamt=0 and passes op_a through.
    always_comb begin
        alu_res_d = '0;
        legal     = 1'b1;
        case (alu_op)
            OP_ADD:  alu_res_d = op_a + op_b;
            OP_SUB:  alu_res_d = op_a - op_b;
            OP_SLT:  alu_res_d = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            OP_SLTU: alu_res_d = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            OP_XOR:  alu_res_d = op_a ^ op_b;
            OP_OR:   alu_res_d = op_a | op_b;
            OP_AND:  alu_res_d = op_a & op_b;
            OP_SLL, OP_SRL, OP_SRA: alu_res_d = op_a;
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= '0;
            wrk_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= alu_op;
                        wrk_q <= op_a;
                        cnt_q <= shamt;
                        if (!legal) begin
                            result_q  <= '0;
                            zero_q    <= 1'b1;
                            illegal_q <= 1'b1;
                            state_q   <= DONE;
                        end else if (is_shift && (shamt != '0)) begin
                            state_q <= SHIFT;
                        end else begin
                            result_q  <= alu_res_d;
                            zero_q    <= (alu_res_d == '0);
                            illegal_q <= 1'b0;
                            state_q   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    wrk_q <= shifted_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == SHW'(1)) begin
                        result_q  <= shifted_d;
                        zero_q    <= (shifted_d == '0);
                        illegal_q <= 1'b0;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = (state_q == DONE);
    assign result     = result_q;
    assign zero       = zero_q;
    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed vector table, handshake/flush/reset sequences,
// and randomized operations checked against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal_op;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    alu_exec_unit #(.XLEN(32), .SHW(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal_op(illegal_op), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        z;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model written from the operation rules, shifts done in one step.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        case (op)
            4'd0:  r = a + b;
            4'd8:  r = a - b;
            4'd1:  r = a << sh;
            4'd5:  r = a >> sh;
            4'd13: r = $signed(a) >>> sh;
            4'd2:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd3:  r = (a < b) ? 32'd1 : 32'd0;
            4'd4:  r = a ^ b;
            4'd6:  r = a | b;
            4'd7:  r = a & b;
            default: begin r = 32'd0; ill = 1'b1; end
        endcase
        if ((op == 4'd1 || op == 4'd5 || op == 4'd13) && sh != 0) lat = sh + 1;
    endtask

    // Issue one op, scramble inputs after accept, wait (bounded) for out_valid without acking.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output logic ill, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
        alu_op = op; op_a = a; op_b = b; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op_a = $urandom; op_b = $urandom; alu_op = 4'($urandom);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 100);
        r = result; z = zero; ill = illegal_op;
    endtask

    task automatic ack();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [31:0] r, er;
    logic        z, ill, eill;
    int          lat, elat, vcount;
    logic [31:0] hold_r;
    logic        hold_z, hold_i;

    initial begin
        vecs[0]  = '{4'b0000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0, 1};
        vecs[1]  = '{4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[2]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0, 1};
        vecs[3]  = '{4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0, 1};
        vecs[4]  = '{4'b1111, 32'h00001234, 32'h00005678, 32'h00000000, 1'b1, 1'b1, 1};
        vecs[5]  = '{4'b1010, 32'hDEADBEEF, 32'h00000003, 32'h00000000, 1'b1, 1'b1, 1};
        vecs[6]  = '{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1};
        vecs[7]  = '{4'b0110, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0, 1};
        vecs[8]  = '{4'b0111, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0F0F0000, 1'b0, 1'b0, 1};
        vecs[9]  = '{4'b0001, 32'hDEADBEEF, 32'h00000020, 32'hDEADBEEF, 1'b0, 1'b0, 1};
        vecs[10] = '{4'b0101, 32'h80000000, 32'hFFFFFF04, 32'h08000000, 1'b0, 1'b0, 5};
        vecs[11] = '{4'b1101, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF, 1'b0, 1'b0, 32};
        vecs[12] = '{4'b0001, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0, 32};
        vecs[13] = '{4'b1000, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        alu_op = 4'd0; op_a = 32'd0; op_b = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, ill, lat);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].z});
            chk($sformatf("vec%0d_illegal", i), {31'd0, ill}, {31'd0, vecs[i].ill});
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            ack();
        end

        // Back-pressure: result held while out_ready stays low, new requests ignored.
        run_op(4'b0100, 32'hAAAA5555, 32'h0000FFFF, r, z, ill, lat);
        chk("hold_first_result", r, 32'hAAAAAAAA);
        hold_r = result; hold_z = zero; hold_i = illegal_op;
        for (int c = 0; c < 5; c++) begin
            in_valid = c[0]; alu_op = 4'b0000; op_a = $urandom; op_b = $urandom;
            @(negedge clk);
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", result, 32'hAAAAAAAA);
            chk("hold_flags", {30'd0, zero, illegal_op}, 32'd0);
        end
        in_valid = 1'b0;
        ack();
        @(negedge clk);
        chk("after_ack_in_ready", {31'd0, in_ready}, 32'd1);
        chk("after_ack_out_valid", {31'd0, out_valid}, 32'd0);
        run_op(4'b0000, 32'd2, 32'd3, r, z, ill, lat);
        chk("after_hold_add", r, 32'd5);
        ack();

        // Flush in the third SHIFT cycle of SLL by 10.
        @(negedge clk);
        alu_op = 4'b0001; op_a = 32'd1; op_b = 32'd10; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        vcount = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (out_valid) vcount++;
            chk("shift_busy", {30'd0, busy, in_ready}, 32'd2);
        end
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", {31'd0, busy}, 32'd0);
        chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 15; c++) begin
            if (out_valid) vcount++;
            @(negedge clk);
        end
        chk("flush_no_out_valid", vcount, 32'd0);

        // Flush wins over a simultaneous request in IDLE.
        flush = 1'b1; in_valid = 1'b1; alu_op = 4'b0000; op_a = 32'd1; op_b = 32'd1;
        @(posedge clk);
        #1 begin flush = 1'b0; in_valid = 1'b0; end
        @(negedge clk);
        chk("flush_idle_busy", {31'd0, busy}, 32'd0);
        chk("flush_idle_out_valid", {31'd0, out_valid}, 32'd0);

        // Asynchronous reset while in DONE.
        run_op(4'b0110, 32'hFFFF0000, 32'h0000FFFF, r, z, ill, lat);
        chk("pre_rst_result", r, 32'hFFFFFFFF);
        #1 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        chk("async_rst_result", result, 32'd0);
        chk("async_rst_flags", {30'd0, zero, illegal_op}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized operations against the reference model.
        for (int i = 0; i < 200; i++) begin
            logic [3:0]  rop;
            logic [31:0] ra, rb;
            rop = 4'($urandom);
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) ra = rb;
            model(rop, ra, rb, er, eill, elat);
            run_op(rop, ra, rb, r, z, ill, lat);
            chk($sformatf("rand%0d_op%0h_result", i, rop), r, er);
            chk($sformatf("rand%0d_zero", i), {31'd0, z}, {31'd0, (er == 32'd0)});
            chk($sformatf("rand%0d_illegal", i), {31'd0, ill}, {31'd0, eill});
            chk($sformatf("rand%0d_latency", i), lat, elat);
            ack();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
